conv_job_sequencer: RTL
=======================

// Module: conv_job_sequencer
// PURPOSE
//  Parametrised front-end sequencer for the conv accelerator. Queues up to JOB_DEPTH conv job descriptors.
//  Per job: routes one shared input stream to the weight buffer, then to the ifmap buffer; beat counts are checked.
//  Then drives params + start_conv into IMG2COL_GEMM, waits for done, then hands the result drain to the stream output.
//  Sits between the AXI-lite/stream shell and the ctrl_unit/buffer/GEMM datapath. Adds job queueing and length checking.
// PARAMETERS
//  DATA_W     32  stream beat width (one element per beat)
//  TENSOR_W    8  tensor side width     | KERNEL_W 4  kernel side width
//  CH_W        8  channel count width   | STRIDE_W 2  stride width
//  KNUM_W      8  kernel count width
//  JOB_DEPTH   4  descriptor FIFO depth (power of 2, >=2)
//  CNT_W      24  beat counter width (>= widest product below)
// PORTS
//  clk           in   1       clock
//  rstn          in   1       synchronous, active-high reset (1 = reset)
//  enable        in   1       0: no new job launched from IDLE; running job completes
//  job_valid     in   1       descriptor push valid
//  job_ready     out  1       FIFO not full
//  job_tensor    in   TENSOR_W  T (ifmap side)
//  job_ksize     in   KERNEL_W  K
//  job_ch        in   CH_W      C
//  job_stride    in   STRIDE_W  S
//  job_knum      in   KNUM_W    N
//  s_data/s_valid/s_last in DATA_W/1/1   shared input stream (weights, then ifmap)
//  s_ready       out  1       input stream ready
//  wb_data/wb_valid/wb_last out DATA_W/1/1; wb_ready in 1   to weight buffer
//  ib_data/ib_valid/ib_last out DATA_W/1/1; ib_ready in 1   to ifmap buffer
//  tensor_size/kernel_size/channels/stride/kernel_nums out  active job params (held for whole job)
//  start_conv    out  1       1-cycle pulse to GEMM
//  conv_done     in   1       GEMM completion pulse (w_done)
//  drain_done    in   1       result stream accepted last beat (r_valid&r_ready&r_last)
//  busy          out  1       FSM != IDLE
//  job_cnt       out  $clog2(JOB_DEPTH)+1   FIFO occupancy
//  err_short/err_long out 1   sticky; cleared only by reset
//  irq_done      out  1       1-cycle pulse per completed job
//  perf_cycles   out  32      see CONFIGURATION
// BEHAVIOUR
//  Reset: FSM IDLE, FIFO empty, all outputs 0 (job_ready=1 after reset deasserts), params 0, errors cleared.
//  FIFO: push on job_valid&job_ready. Push while full is ignored. Simultaneous push+pop when full is allowed.
//  FSM states: IDLE -> CALC -> LOAD_W -> LOAD_I -> START -> RUN -> DRAIN -> IDLE; plus SKIP (ret = LOAD_I | START).
//   IDLE:  if enable & FIFO non-empty: pop, latch params -> CALC.
//   CALC:  1 cycle; exp_w = K*K*C*N, exp_i = T*T*C registered at CNT_W, zero-extended.
//   LOAD_W: s_ready=wb_ready, wb_valid=s_valid, wb_data=s_data (combinational, 0 latency).
//    wb_last = s_last | (cnt==exp_w-1). Count on s_valid&s_ready.
//    Beat with s_last before count reached: err_short<=1, phase ends (-> LOAD_I).
//    Count reached without s_last: err_long<=1, -> SKIP (s_ready=1, beats dropped until s_last), then LOAD_I.
//    Both on the same beat: normal end.
//   LOAD_I: identical rules using ib_*, exp_i; next -> START.
//   START: start_conv=1 for exactly one cycle -> RUN.
//   RUN:   wait conv_done -> DRAIN. conv_done outside RUN is ignored.
//   DRAIN: wait drain_done -> irq_done pulse same cycle as the IDLE transition.
//  Counter reset to 0 at every phase entry. Zero product (any param 0): phase skipped, no beats consumed.
//  s_ready=0 in all states except LOAD_W/LOAD_I/SKIP. wb_valid/ib_valid only in their own phase.
//  Back-to-back: next job may launch the cycle after returning to IDLE (min 1 IDLE cycle).
//  Reset mid-job: immediate IDLE, queued jobs discarded, no irq_done.
// CONFIGURATION
//  CONV_SEQ_PERF_EN defined: perf_cycles counts cycles from CALC entry to DRAIN exit.
//   Holds last job's value. Saturates at 2^32-1.
//  Undefined: perf_cycles tied to 0, no counter logic.
// TESTING
//  T=4,K=3,C=1,N=2,S=1, 18 W + 16 I beats, last on the final beat of each phase
//   -> 18 wb beats (wb_last on #18), 16 ib beats, 1 start_conv, irq_done after drain_done, no errors.
//  Same job, s_last on W beat 10 -> err_short=1, ib receives next 16 beats, job completes.
//  Same job, 20 W beats, s_last on #20 -> wb_last on #18, beats 19-20 dropped, err_long=1.
//  Push 5 jobs at enable=0 -> job_ready=0 after 4, job_cnt=4. Raise enable -> 4 jobs run in order, 4 irq_done.
//  Reset asserted in RUN with 2 queued -> busy=0, job_cnt=0, start_conv stays 0, errors 0.
//  PERF_EN, ready always 1, conv_done 5 cycles after start, drain_done 3 cycles later
//   -> perf_cycles = 1+18+16+1+5+3 (+/-1 per documented edge) matches bench model.

Source files
------------

// File: rtl/conv_job_sequencer.sv
// Conv accelerator front-end: queues job descriptors, routes the shared input stream to the
// weight then ifmap buffers with length checking, and sequences GEMM start and result drain.
// Optional cycle counter is enabled by defining CONV_SEQ_PERF_EN.
module conv_job_sequencer #(
  parameter int DATA_W    = 32,
  parameter int TENSOR_W  = 8,
  parameter int KERNEL_W  = 4,
  parameter int CH_W      = 8,
  parameter int STRIDE_W  = 2,
  parameter int KNUM_W    = 8,
  parameter int JOB_DEPTH = 4,
  parameter int CNT_W     = 24
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         enable_i,
  input  logic                         job_valid_i,
  output logic                         job_ready_o,
  input  logic [TENSOR_W-1:0]          job_tensor_i,
  input  logic [KERNEL_W-1:0]          job_ksize_i,
  input  logic [CH_W-1:0]              job_ch_i,
  input  logic [STRIDE_W-1:0]          job_stride_i,
  input  logic [KNUM_W-1:0]            job_knum_i,
  input  logic [DATA_W-1:0]            s_data_i,
  input  logic                         s_valid_i,
  input  logic                         s_last_i,
  output logic                         s_ready_o,
  output logic [DATA_W-1:0]            wb_data_o,
  output logic                         wb_valid_o,
  output logic                         wb_last_o,
  input  logic                         wb_ready_i,
  output logic [DATA_W-1:0]            ib_data_o,
  output logic                         ib_valid_o,
  output logic                         ib_last_o,
  input  logic                         ib_ready_i,
  output logic [TENSOR_W-1:0]          tensor_size_o,
  output logic [KERNEL_W-1:0]          kernel_size_o,
  output logic [CH_W-1:0]              channels_o,
  output logic [STRIDE_W-1:0]          stride_o,
  output logic [KNUM_W-1:0]            kernel_nums_o,
  output logic                         start_conv_o,
  input  logic                         conv_done_i,
  input  logic                         drain_done_i,
  output logic                         busy_o,
  output logic [$clog2(JOB_DEPTH):0]   job_cnt_o,
  output logic                         err_short_o,
  output logic                         err_long_o,
  output logic                         irq_done_o,
  output logic [31:0]                  perf_cycles_o
);

  localparam int PTR_W  = $clog2(JOB_DEPTH);
  localparam int DESC_W = TENSOR_W + KERNEL_W + CH_W + STRIDE_W + KNUM_W;
  localparam int PW_W   = 2 * KERNEL_W + CH_W + KNUM_W;
  localparam int PI_W   = 2 * TENSOR_W + CH_W;

  typedef enum logic [2:0] {
    IDLE, CALC, LOAD_W, LOAD_I, SKIP, START, RUN, DRAIN
  } state_e;

  state_e               state_q;
  state_e               retState_q;
  state_e               afterPhase;
  logic [DESC_W-1:0]    fifoMem_q [JOB_DEPTH];
  logic [PTR_W-1:0]     wrPtr_q;
  logic [PTR_W-1:0]     rdPtr_q;
  logic [PTR_W:0]       count_q;
  logic                 full;
  logic                 push;
  logic                 pop;
  logic [TENSOR_W-1:0]  tensor_q;
  logic [KERNEL_W-1:0]  ksize_q;
  logic [CH_W-1:0]      ch_q;
  logic [STRIDE_W-1:0]  stride_q;
  logic [KNUM_W-1:0]    knum_q;
  logic [CNT_W-1:0]     expW_q;
  logic [CNT_W-1:0]     expI_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     expCur;
  logic [CNT_W-1:0]     expWNext;
  logic [CNT_W-1:0]     expINext;
  logic [PW_W-1:0]      prodW;
  logic [PI_W-1:0]      prodI;
  logic                 atEnd;
  logic                 beat;
  logic                 errShort_q;
  logic                 errLong_q;
  logic                 irqDone_q;

  // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
  assign full        = (count_q == (PTR_W + 1)'(JOB_DEPTH));
  assign pop         = (state_q == IDLE) && enable_i && (count_q != '0);
  assign job_ready_o = !rstn_i && (!full || pop);
  assign push        = job_valid_i && job_ready_o;

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifoMem_q[wrPtr_q] <= {job_tensor_i, job_ksize_i, job_ch_i, job_stride_i, job_knum_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rstn_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + PTR_W'(1);
      if (pop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + (PTR_W + 1)'(1);
      else if (pop && !push) count_q <= count_q - (PTR_W + 1)'(1);
    end
  end

  assign prodW    = PW_W'(ksize_q) * PW_W'(ksize_q) * PW_W'(ch_q) * PW_W'(knum_q);
  assign prodI    = PI_W'(tensor_q) * PI_W'(tensor_q) * PI_W'(ch_q);
  assign expWNext = CNT_W'(prodW);
  assign expINext = CNT_W'(prodI);

  assign expCur     = (state_q == LOAD_I) ? expI_q : expW_q;
  assign atEnd      = (cnt_q == expCur - CNT_W'(1));
  assign beat       = s_valid_i && s_ready_o;
  assign afterPhase = (state_q == LOAD_W && expI_q != '0) ? LOAD_I : START;

  always_comb begin
    s_ready_o  = 1'b0;
    wb_valid_o = 1'b0;
    wb_last_o  = 1'b0;
    ib_valid_o = 1'b0;
    ib_last_o  = 1'b0;
    unique case (state_q)
      LOAD_W: begin
        s_ready_o  = wb_ready_i;
        wb_valid_o = s_valid_i;
        wb_last_o  = s_last_i || atEnd;
      end
      LOAD_I: begin
        s_ready_o  = ib_ready_i;
        ib_valid_o = s_valid_i;
        ib_last_o  = s_last_i || atEnd;
      end
      SKIP:    s_ready_o = 1'b1;
      default: s_ready_o = 1'b0;
    endcase
  end

  assign wb_data_o = s_data_i;
  assign ib_data_o = s_data_i;

  // Early s_last flags a short phase; reaching the count first flags long and drops the tail.
  always_ff @(posedge clk_i) begin
    if (rstn_i) begin
      state_q    <= IDLE;
      retState_q <= IDLE;
      tensor_q   <= '0;
      ksize_q    <= '0;
      ch_q       <= '0;
      stride_q   <= '0;
      knum_q     <= '0;
      expW_q     <= '0;
      expI_q     <= '0;
      cnt_q      <= '0;
      errShort_q <= 1'b0;
      errLong_q  <= 1'b0;
      irqDone_q  <= 1'b0;
    end else begin
      irqDone_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            {tensor_q, ksize_q, ch_q, stride_q, knum_q} <= fifoMem_q[rdPtr_q];
            state_q <= CALC;
          end
        end
        CALC: begin
          expW_q <= expWNext;
          expI_q <= expINext;
          cnt_q  <= '0;
          if (expWNext != '0)      state_q <= LOAD_W;
          else if (expINext != '0) state_q <= LOAD_I;
          else                     state_q <= START;
        end
        LOAD_W, LOAD_I: begin
          if (beat) begin
            if (s_last_i) begin
              if (!atEnd) errShort_q <= 1'b1;
              cnt_q   <= '0;
              state_q <= afterPhase;
            end else if (atEnd) begin
              errLong_q  <= 1'b1;
              cnt_q      <= '0;
              retState_q <= afterPhase;
              state_q    <= SKIP;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        SKIP: begin
          if (s_valid_i && s_last_i) state_q <= retState_q;
        end
        START: state_q <= RUN;
        RUN: begin
          if (conv_done_i) state_q <= DRAIN;
        end
        DRAIN: begin
          if (drain_done_i) begin
            state_q   <= IDLE;
            irqDone_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign tensor_size_o = tensor_q;
  assign kernel_size_o = ksize_q;
  assign channels_o    = ch_q;
  assign stride_o      = stride_q;
  assign kernel_nums_o = knum_q;
  assign start_conv_o  = (state_q == START);
  assign busy_o        = (state_q != IDLE);
  assign job_cnt_o     = count_q;
  assign err_short_o   = errShort_q;
  assign err_long_o    = errLong_q;
  assign irq_done_o    = irqDone_q;

`ifdef CONV_SEQ_PERF_EN
  logic [31:0] perf_q;

  // Every non-IDLE cycle of a job is counted; the value is held until the next launch.
  always_ff @(posedge clk_i) begin
    if (rstn_i) begin
      perf_q <= '0;
    end else if (pop) begin
      perf_q <= '0;
    end else if (state_q != IDLE && perf_q != '1) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles_o = perf_q;
`else
  assign perf_cycles_o = '0;
`endif

endmodule
